// File: rtl/usr_pkg.sv
// Shared constants for the 4-bit universal shift register lab top level.
package usr_pkg;

    localparam int unsigned SYS_CLK_HZ     = 100_000_000;
    localparam int unsigned TICK_HZ        = 500;
    localparam int unsigned DEF_CLK_DIV    = SYS_CLK_HZ / TICK_HZ;
    localparam int unsigned DEF_DB_SAMPLES = 8;

    // Shift-register mode encoding used by the neighbouring register block.
    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_LOAD = 2'b01,
        MODE_ROTL = 2'b10,
        MODE_SHR  = 2'b11
    } usr_mode_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running divider: one-cycle tick every CLK_DIV clocks.
module tick_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned CntW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    logic [CntW-1:0] count_q;
    logic [CntW-1:0] count_d;

    // Tick is decoded from the terminal count, so it is low while in reset.
    always_comb begin
        tick    = (count_q == CntW'(CLK_DIV - 1));
        count_d = tick ? '0 : count_q + CntW'(1);
    end

    // Divider count register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/step_pulse_gen.sv
// Pushbutton conditioner: sync, tick-sampled debounce and rising-edge one-shot.
// Optional auto-repeat while held: define STEP_PULSE_AUTO_REPEAT_EN.
module step_pulse_gen
    import usr_pkg::*;
#(
    parameter int unsigned CLK_DIV    = DEF_CLK_DIV,
    parameter int unsigned DB_SAMPLES = DEF_DB_SAMPLES,
    parameter int unsigned REPEAT_DLY = 250,
    parameter int unsigned REPEAT_PER = 50
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic tick,
    output logic btn_level,
    output logic step_pulse
);

    logic                  sync1_q, sync2_q;
    logic [DB_SAMPLES-1:0] hist_q, hist_d;
    logic                  level_q, level_d;
    logic                  step_q, step_d;
    logic                  rise;

    tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tick_gen (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    // Two-flop synchronizer for the asynchronous button.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_in;
            sync2_q <= sync1_q;
        end
    end

    // History shift on tick; level follows only a unanimous history.
    always_comb begin
        hist_d = hist_q;
        if (tick) begin
            hist_d = {hist_q[DB_SAMPLES-2:0], sync2_q};
        end
        level_d = level_q;
        if (&hist_q) begin
            level_d = 1'b1;
        end else if (~|hist_q) begin
            level_d = 1'b0;
        end
        rise = level_d & ~level_q;
    end

`ifdef STEP_PULSE_AUTO_REPEAT_EN
    localparam int unsigned RepW = $clog2(max_u(REPEAT_DLY, REPEAT_PER) + 1);

    logic [RepW-1:0] rep_cnt_q, rep_cnt_d;
    logic [RepW-1:0] rep_inc, rep_target;
    logic            rep_armed_q, rep_armed_d;
    logic            rep_fire;

    // Count held ticks; first target is the delay, later ones the period.
    always_comb begin
        rep_cnt_d   = rep_cnt_q;
        rep_armed_d = rep_armed_q;
        rep_fire    = 1'b0;
        rep_inc     = rep_cnt_q + RepW'(1);
        rep_target  = rep_armed_q ? RepW'(REPEAT_PER) : RepW'(REPEAT_DLY);
        if (!level_q) begin
            rep_cnt_d   = '0;
            rep_armed_d = 1'b0;
        end else if (tick) begin
            if (rep_inc == rep_target) begin
                rep_fire    = 1'b1;
                rep_cnt_d   = '0;
                rep_armed_d = 1'b1;
            end else begin
                rep_cnt_d = rep_inc;
            end
        end
        step_d = rise | rep_fire;
    end

    // Auto-repeat counter state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rep_cnt_q   <= '0;
            rep_armed_q <= 1'b0;
        end else begin
            rep_cnt_q   <= rep_cnt_d;
            rep_armed_q <= rep_armed_d;
        end
    end
`else
    logic unused_repeat;
    assign unused_repeat = ^{REPEAT_DLY, REPEAT_PER};

    // Single pulse per press.
    always_comb begin
        step_d = rise;
    end
`endif

    // Debounce history, level and one-shot registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_q  <= '0;
            level_q <= 1'b0;
            step_q  <= 1'b0;
        end else begin
            hist_q  <= hist_d;
            level_q <= level_d;
            step_q  <= step_d;
        end
    end

    assign btn_level  = level_q;
    assign step_pulse = step_q;

endmodule

// File: tb/tb_step_pulse_gen.sv
// Self-checking bench for step_pulse_gen with a run-length reference model.
module tb_step_pulse_gen;

    localparam int CLK_DIV = 4;
    localparam int DB      = 4;
    localparam int DLY     = 5;
    localparam int PER     = 2;

    logic clk, rst, btn_in;
    logic tick, btn_level, step_pulse;

    step_pulse_gen #(
        .CLK_DIV   (CLK_DIV),
        .DB_SAMPLES(DB),
        .REPEAT_DLY(DLY),
        .REPEAT_PER(PER)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_in    (btn_in),
        .tick      (tick),
        .btn_level (btn_level),
        .step_pulse(step_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks, n_pass, n_fail;
    int n_pulses, edge_cnt, first_tick, first_pulse, first_level, lvl_seen;

    // Reference model: sample stream tracked as a run of equal values.
    int m_cyc, m_run_len, m_pulses, m_rep;
    bit m_s1, m_s2, m_run_val, m_level, m_pulse;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_cyc = 0; m_s1 = 0; m_s2 = 0;
        m_run_val = 0; m_run_len = DB;
        m_level = 0; m_pulse = 0; m_rep = 0;
    endtask

    task automatic model_edge();
        bit tick_now, lvl_old, lvl_new, fire;
        if (!rst) begin
            model_reset();
        end else begin
            tick_now = (m_cyc % CLK_DIV) == CLK_DIV - 1;
            lvl_old  = m_level;
            lvl_new  = lvl_old;
            fire     = 0;
            if (m_run_len >= DB) lvl_new = m_run_val;
`ifdef STEP_PULSE_AUTO_REPEAT_EN
            if (!lvl_old) m_rep = 0;
            else if (tick_now) begin
                m_rep++;
                if (m_rep == DLY || (m_rep > DLY && (m_rep - DLY) % PER == 0)) fire = 1;
            end
`endif
            if (tick_now) begin
                if (m_s2 == m_run_val) begin
                    if (m_run_len < 64) m_run_len++;
                end else begin
                    m_run_val = m_s2;
                    m_run_len = 1;
                end
            end
            m_s2    = m_s1;
            m_s1    = btn_in;
            m_pulse = (lvl_new && !lvl_old) || fire;
            m_level = lvl_new;
            m_cyc++;
            if (m_pulse) m_pulses++;
        end
    endtask

    function automatic logic [31:0] model_out();
        bit t;
        t = (m_cyc % CLK_DIV) == CLK_DIV - 1;
        return 32'({t, m_level, m_pulse});
    endfunction

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check("outputs", 32'({tick, btn_level, step_pulse}), model_out());
        edge_cnt++;
        if (step_pulse) n_pulses++;
        if (btn_level) lvl_seen = 1;
        if (tick && first_tick < 0) first_tick = edge_cnt;
        if (step_pulse && first_pulse < 0) first_pulse = edge_cnt;
        if (btn_level && first_level < 0) first_level = edge_cnt;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic mark();
        edge_cnt = 0; n_pulses = 0; first_tick = -1; first_pulse = -1;
        first_level = -1; lvl_seen = 0; m_pulses = 0;
    endtask

    initial begin
        int guard;
        n_checks = 0; n_pass = 0; n_fail = 0;
        model_reset();
        mark();
        rst = 1'b0;
        btn_in = 1'b1;

        // Reset held with the button pressed.
        #1;
        check("reset_outputs", 32'({tick, btn_level, step_pulse}), 32'd0);
        run(3);
        rst = 1'b1;
        mark();
        run(30);
        check("rst_first_tick", 32'(first_tick), 32'd3);
        check("rst_first_pulse", 32'(first_pulse), 32'd17);
        check("rst_pulse_count", 32'(n_pulses), 32'd1);
        check("rst_level_held", 32'(btn_level), 32'd1);

        // Clean press and release.
        btn_in = 1'b0; mark(); run(40);
        check("idle_level", 32'(btn_level), 32'd0);
        btn_in = 1'b1; mark(); run(32);
        check("press_pulses", 32'(n_pulses), 32'd1);
        check("press_latency_ok", 32'(first_level >= 0 && first_level <= 22), 32'd1);
        btn_in = 1'b0; mark(); run(40);
        check("release_pulses", 32'(n_pulses), 32'd0);
        check("release_level", 32'(btn_level), 32'd0);

        // Bounce: toggling every 3 cycles never debounces.
        mark();
        for (int i = 0; i < 10; i++) begin
            btn_in = ~btn_in;
            run(3);
        end
        check("bounce_pulses", 32'(n_pulses), 32'd0);
        btn_in = 1'b1; mark(); run(32);
        check("bounce_settle_pulses", 32'(n_pulses), 32'd1);
        btn_in = 1'b0; run(40);

        // One-tick glitch while idle.
        mark();
        btn_in = 1'b1; run(CLK_DIV);
        btn_in = 1'b0; run(40);
        check("glitch_level", 32'(lvl_seen), 32'd0);
        check("glitch_pulses", 32'(n_pulses), 32'd0);

        // Reset asserted once three of four samples are high.
        btn_in = 1'b1;
        guard = 0;
        while (!(m_run_val && m_run_len == 3) && guard < 100) begin
            cyc();
            guard++;
        end
        check("hist_0111_reached", 32'(guard < 100), 32'd1);
        #1;
        rst = 1'b0;
        model_reset();
        #1;
        check("async_clear", 32'({tick, btn_level, step_pulse}), model_out());
        cyc();
        rst = 1'b1;
        mark();
        run(30);
        check("mid_rst_first_pulse", 32'(first_pulse), 32'd17);
        check("mid_rst_pulses", 32'(n_pulses), 32'd1);
        btn_in = 1'b0; run(40);

        // Long hold: auto-repeat when enabled, single pulse otherwise.
        mark();
        btn_in = 1'b1; run(80);
        btn_in = 1'b0; run(40);
        check("hold_pulses_model", 32'(n_pulses), 32'(m_pulses));
`ifndef STEP_PULSE_AUTO_REPEAT_EN
        check("hold_single_pulse", 32'(n_pulses), 32'd1);
`endif

        // Random presses and holds against the model.
        for (int k = 0; k < 30; k++) begin
            btn_in = 1'($urandom_range(0, 1));
            run(int'($urandom_range(1, 60)));
        end
        btn_in = 1'b0;
        run(40);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
